// File: rtl/acq_pkg.sv
// Shared types, record layout and tag decode for the ADC acquisition controller.
package acq_pkg;

  typedef logic [0:0] acq_state_t;
  localparam acq_state_t StIdle = 1'b0;
  localparam acq_state_t StAcq  = 1'b1;

  localparam int unsigned DEF_ADC_W = 12;
  localparam int unsigned DEF_CNT_W = 8;
  localparam int unsigned ROT_W     = 10;
  localparam int unsigned CHAN_W    = 2;

  // rec_data field offsets at the default widths, MSB first: err,sat,chan,rot,cnt,sum,peak
  localparam int unsigned PEAK_LSB  = 0;
  localparam int unsigned SUM_LSB   = PEAK_LSB + DEF_ADC_W;
  localparam int unsigned CNT_LSB   = SUM_LSB + DEF_ADC_W + DEF_CNT_W;
  localparam int unsigned ROT_LSB   = CNT_LSB + DEF_CNT_W;
  localparam int unsigned CHAN_LSB  = ROT_LSB + ROT_W;
  localparam int unsigned SAT_BIT   = CHAN_LSB + CHAN_W;
  localparam int unsigned ERR_BIT   = SAT_BIT + 1;
  localparam int unsigned REC_W_DEF = ERR_BIT + 1;

  // Returns {err, idx}; zero or multi-hot input reports err with idx 0.
  function automatic logic [2:0] onehot4_to_idx(input logic [3:0] oh);
    logic [2:0] res;
    res = 3'b100;
    unique case (oh)
      4'b0001: res = 3'b000;
      4'b0010: res = 3'b001;
      4'b0100: res = 3'b010;
      4'b1000: res = 3'b011;
      default: res = 3'b100;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/acq_rec_fifo.sv
// First-word-fall-through record FIFO; a push into a full FIFO is accepted only
// when a pop frees the head slot on the same edge.
module acq_rec_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 54
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wptr_q, wptr_d, rptr_q, rptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) wptr_d = wptr_q + {{AW{1'b0}}, 1'b1};
    if (do_pop)  rptr_d = rptr_q + {{AW{1'b0}}, 1'b1};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

  // Masked so the read port shows zero whenever nothing is valid.
  assign rdata_o = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];

endmodule

// File: rtl/adc_acq_ctrl.sv
// ADC window accumulator: tags each adc_en window and queues one record per window.
// Define ACQ_PEAK_EN to fill the peak field with the window maximum.
module adc_acq_ctrl
  import acq_pkg::*;
#(
  parameter int unsigned ADC_W  = DEF_ADC_W,
  parameter int unsigned CNT_W  = DEF_CNT_W,
  parameter int unsigned FIFO_D = 8,
  parameter int unsigned REC_W  = 2 + CHAN_W + ROT_W + CNT_W + (ADC_W + CNT_W) + ADC_W
) (
  input  logic             stp_clk,
  input  logic             sys_init_ctrl,
  input  logic             adc_en,
  input  logic [3:0]       rf_sw,
  input  logic [ROT_W-1:0] rot_count,
  input  logic [ADC_W-1:0] adc_data,
  input  logic             adc_dvld,
  output logic [REC_W-1:0] rec_data,
  output logic             rec_vld,
  input  logic             rec_rdy,
  output logic             ovf,
  output logic             busy
);

  localparam int unsigned SUM_W = ADC_W + CNT_W;

  acq_state_t        state_q, state_d;
  logic              en_q;
  logic              err_q, err_d;
  logic [CHAN_W-1:0] chan_q, chan_d;
  logic [ROT_W-1:0]  rot_q, rot_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic              ovf_q, ovf_d;
  logic [ADC_W-1:0]  peak;
  logic [2:0]        tag;
  logic              rise, fall, take, cnt_max, sat, push, pop, full, empty;
  logic [SUM_W-1:0]  sample_ext;

  assign rise       = adc_en & ~en_q;
  assign fall       = ~adc_en & en_q;
  assign take       = adc_en & adc_dvld;
  assign cnt_max    = &cnt_q;
  assign sat        = cnt_max;
  assign tag        = onehot4_to_idx(rf_sw);
  assign sample_ext = {{CNT_W{1'b0}}, adc_data};

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    chan_d  = chan_q;
    rot_d   = rot_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    case (state_q)
      StIdle: begin
        if (rise) begin
          state_d = StAcq;
          err_d   = tag[2];
          chan_d  = tag[1:0];
          rot_d   = rot_count;
          cnt_d   = take ? CNT_W'(1) : '0;
          sum_d   = take ? sample_ext : '0;
        end
      end
      StAcq: begin
        if (fall) begin
          state_d = StIdle;
        end else if (take && !cnt_max) begin
          cnt_d = cnt_q + CNT_W'(1);
          sum_d = sum_q + sample_ext;
        end
      end
      default: state_d = StIdle;
    endcase
  end

`ifdef ACQ_PEAK_EN
  logic [ADC_W-1:0] peak_q, peak_d;

  always_comb begin
    peak_d = peak_q;
    if (state_q == StIdle) begin
      if (rise) peak_d = take ? adc_data : '0;
    end else if (!fall && take && !cnt_max && (adc_data > peak_q)) begin
      peak_d = adc_data;
    end
  end

  always_ff @(posedge stp_clk or posedge sys_init_ctrl) begin
    if (sys_init_ctrl) peak_q <= '0;
    else               peak_q <= peak_d;
  end

  assign peak = peak_q;
`else
  assign peak = '0;
`endif

  assign push  = (state_q == StAcq) & fall;
  assign pop   = rec_rdy & ~empty;
  // A same-edge pop makes room, so only an unrelieved full push is a drop.
  assign ovf_d = ovf_q | (push & full & ~pop);

  always_ff @(posedge stp_clk or posedge sys_init_ctrl) begin
    if (sys_init_ctrl) begin
      state_q <= StIdle;
      en_q    <= 1'b0;
      err_q   <= 1'b0;
      chan_q  <= '0;
      rot_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      en_q    <= adc_en;
      err_q   <= err_d;
      chan_q  <= chan_d;
      rot_q   <= rot_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      ovf_q   <= ovf_d;
    end
  end

  acq_rec_fifo #(
    .DEPTH (FIFO_D),
    .WIDTH (REC_W)
  ) u_fifo (
    .clk_i   (stp_clk),
    .rst_i   (sys_init_ctrl),
    .push_i  (push),
    .wdata_i ({err_q, sat, chan_q, rot_q, cnt_q, sum_q, peak}),
    .pop_i   (rec_rdy),
    .rdata_o (rec_data),
    .full_o  (full),
    .empty_o (empty)
  );

  assign rec_vld = ~empty;
  assign ovf     = ovf_q;
  assign busy    = (state_q == StAcq);

endmodule
